// File: rtl/reg_scoreboard.sv
// reg_scoreboard: register-busy scoreboard for the pipelined MIPS core.
// Each issued destination sets a per-register busy bit. Any of NUM_WB
// writeback ports clears it. Issue stalls on RAW/WAW hazards through
// iss_valid/iss_ready.
// Optional build macro SCOREBOARD_BYPASS_EN: a same-cycle writeback hides
// the busy bit from the hazard check, so a stalled consumer issues without
// waiting an extra cycle. If that writeback meets a new set of the same
// register, the set wins.

// One busy bit for a single architectural register (registers 1..NUM_REGS-1)
module reg_scoreboard_cell (
  input  logic clock,
  input  logic ctrl_reset_n,
  input  logic i_set,
  input  logic i_clr,
  output logic o_busy,
  output logic o_busy_nxt,
  output logic o_busy_eff
);
  logic r_busy;

  // The set term is ORed in last so that a new producer wins over the
  // writeback of the old one.
  assign o_busy_nxt = i_set | (r_busy & ~i_clr);
  assign o_busy     = r_busy;

`ifdef SCOREBOARD_BYPASS_EN
  assign o_busy_eff = r_busy & ~i_clr;
`else
  assign o_busy_eff = r_busy;
`endif

  // Busy state register with synchronous reset
  always_ff @(posedge clock) begin
    if (!ctrl_reset_n) r_busy <= 1'b0;
    else               r_busy <= o_busy_nxt;
  end
endmodule

module reg_scoreboard #(
  parameter int ADDR_W = 5,
  parameter int NUM_WB = 2
) (
  input  logic                     clock,
  input  logic                     ctrl_reset_n,
  input  logic                     iss_valid,
  output logic                     iss_ready,
  input  logic [ADDR_W-1:0]        iss_rs,
  input  logic [ADDR_W-1:0]        iss_rt,
  input  logic [ADDR_W-1:0]        iss_rd,
  input  logic                     iss_rd_we,
  input  logic [NUM_WB-1:0]        wb_valid,
  input  logic [NUM_WB*ADDR_W-1:0] wb_rd,
  output logic [(2**ADDR_W)-1:0]   busy,
  output logic [ADDR_W:0]          busy_cnt,
  output logic                     err_wb_idle
);
  localparam int NUM_REGS = 2**ADDR_W;

  logic [NUM_WB-1:0][ADDR_W-1:0] w_wb_rd;
  logic [NUM_REGS-1:0]           w_busy;
  logic [NUM_REGS-1:0]           w_busy_nxt;
  logic [NUM_REGS-1:0]           w_busy_eff;
  logic                          w_hazard;
  logic                          w_fire;
  logic                          w_err_hit;
  logic [ADDR_W:0]               w_cnt_nxt;
  logic [ADDR_W:0]               r_busy_cnt;
  logic                          r_err;

  // Port k is stored in wb_rd[k*ADDR_W +: ADDR_W]. The packed 2-D view
  // gives the same layout.
  assign w_wb_rd = wb_rd;

  // RAW on either source, WAW on the destination only when it is written
  assign w_hazard  = w_busy_eff[iss_rs] | w_busy_eff[iss_rt] |
                     (iss_rd_we & w_busy_eff[iss_rd]);
  assign iss_ready = ~w_hazard & ctrl_reset_n;
  assign w_fire    = iss_valid & iss_ready;

  // Register 0 is hardwired: never busy, never set, never cleared
  assign w_busy[0]     = 1'b0;
  assign w_busy_nxt[0] = 1'b0;
  assign w_busy_eff[0] = 1'b0;

  for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_reg
    logic w_set;
    logic w_clr;

    // One-hot decode of the issuing destination
    assign w_set = w_fire & iss_rd_we & (iss_rd == ADDR_W'(gi));

    // OR of all writeback ports that name this register. Several ports
    // naming the same register clear it only once.
    always_comb begin
      w_clr = 1'b0;
      for (int k = 0; k < NUM_WB; k++)
        if (wb_valid[k] && (w_wb_rd[k] == ADDR_W'(gi))) w_clr = 1'b1;
    end

    reg_scoreboard_cell u_cell (
      .clock        (clock),
      .ctrl_reset_n (ctrl_reset_n),
      .i_set        (w_set),
      .i_clr        (w_clr),
      .o_busy       (w_busy[gi]),
      .o_busy_nxt   (w_busy_nxt[gi]),
      .o_busy_eff   (w_busy_eff[gi])
    );
  end

  // Writeback to a non-zero register whose registered busy bit is clear
  always_comb begin
    w_err_hit = 1'b0;
    for (int k = 0; k < NUM_WB; k++)
      if (wb_valid[k] && (w_wb_rd[k] != '0) && !w_busy[w_wb_rd[k]])
        w_err_hit = 1'b1;
  end

  // Popcount of the next busy vector, so busy_cnt tracks busy on the same edge
  always_comb begin
    w_cnt_nxt = '0;
    for (int i = 0; i < NUM_REGS; i++)
      w_cnt_nxt = w_cnt_nxt + (ADDR_W+1)'(w_busy_nxt[i]);
  end

  // Registered count and sticky error flag
  always_ff @(posedge clock) begin
    if (!ctrl_reset_n) begin
      r_busy_cnt <= '0;
      r_err      <= 1'b0;
    end else begin
      r_busy_cnt <= w_cnt_nxt;
      if (w_err_hit) r_err <= 1'b1;
    end
  end

  assign busy        = w_busy;
  assign busy_cnt    = r_busy_cnt;
  assign err_wb_idle = r_err;
endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard (ADDR_W=5, NUM_WB=2). The stimulus pushes
// hand-computed expectations tagged with their cycle. A separate monitor pops
// those expectations and compares them on the falling edge.
module tb_reg_scoreboard;
  localparam int AW = 5;
  localparam int NW = 2;
  localparam int NR = 32;

  logic           clock = 1'b0;
  logic           ctrl_reset_n;
  logic           iss_valid;
  logic           iss_ready;
  logic [AW-1:0]  iss_rs, iss_rt, iss_rd;
  logic           iss_rd_we;
  logic [NW-1:0]  wb_valid;
  logic [NW*AW-1:0] wb_rd;
  logic [NR-1:0]  busy;
  logic [AW:0]    busy_cnt;
  logic           err_wb_idle;

  always #5 clock = ~clock;

  reg_scoreboard #(.ADDR_W(AW), .NUM_WB(NW)) dut (
    .clock        (clock),
    .ctrl_reset_n (ctrl_reset_n),
    .iss_valid    (iss_valid),
    .iss_ready    (iss_ready),
    .iss_rs       (iss_rs),
    .iss_rt       (iss_rt),
    .iss_rd       (iss_rd),
    .iss_rd_we    (iss_rd_we),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .busy         (busy),
    .busy_cnt     (busy_cnt),
    .err_wb_idle  (err_wb_idle)
  );

  typedef struct {
    int          cyc;
    string       nm;
    logic        rdy;
    logic [31:0] bsy;
    logic [5:0]  cnt;
    logic        err;
  } exp_t;

  exp_t q[$];
  int   cyc     = 0;
  int   n_total = 0;
  int   n_bad   = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic cmp(input string nm, input string fld,
                     input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s.%s got=%h want=%h", nm, fld, act, exp);
    end
  endtask

  // Monitor: compare every expectation whose cycle has come
  always @(negedge clock) begin
    exp_t e;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      if (e.cyc < cyc) begin
        n_total++;
        n_bad++;
        $display("FAIL %s.missed got=cycle%0d want=cycle%0d", e.nm, cyc, e.cyc);
      end else begin
        cmp(e.nm, "ready", {31'b0, iss_ready},   {31'b0, e.rdy});
        cmp(e.nm, "busy",  busy,                 e.bsy);
        cmp(e.nm, "cnt",   {26'b0, busy_cnt},    {26'b0, e.cnt});
        cmp(e.nm, "err",   {31'b0, err_wb_idle}, {31'b0, e.err});
      end
    end
  end

  // Drive one cycle of inputs and queue the expected outputs for that cycle.
  // busy/cnt/err reflect state from earlier cycles. ready reflects these inputs.
  task automatic step(input logic rst, input logic v,
                      input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                      input logic [AW-1:0] rd, input logic we,
                      input logic [1:0] wbv, input logic [AW-1:0] w0,
                      input logic [AW-1:0] w1,
                      input logic rdy, input logic [31:0] b,
                      input logic [5:0] c, input logic e, input string nm);
    exp_t x;
    @(posedge clock); #1;
    ctrl_reset_n = rst; iss_valid = v;
    iss_rs = rs; iss_rt = rt; iss_rd = rd; iss_rd_we = we;
    wb_valid = wbv; wb_rd = {w1, w0};
    x.cyc = cyc; x.nm = nm; x.rdy = rdy; x.bsy = b; x.cnt = c; x.err = e;
    q.push_back(x);
  endtask

  initial begin
    ctrl_reset_n = 1'b0; iss_valid = 1'b0; iss_rs = '0; iss_rt = '0;
    iss_rd = '0; iss_rd_we = 1'b0; wb_valid = '0; wb_rd = '0;

    //   rst v  rs  rt  rd  we wbv    w0  w1  rdy busy          cnt e
    // Reset: issue and writeback are dropped while reset is low
    step(0, 1,  0,  0,  8, 1, 2'b01,  5,  0,  0, 32'h0,        0, 0, "reset_hold");
    step(1, 0,  0,  0,  0, 0, 2'b00,  0,  0,  1, 32'h0,        0, 0, "reset_idle");
    // RAW on rs
    step(1, 1,  0,  0,  8, 1, 2'b00,  0,  0,  1, 32'h0,        0, 0, "fire_rd8");
    step(1, 1,  8,  0,  0, 0, 2'b00,  0,  0,  0, 32'h100,      1, 0, "raw_stall");
`ifdef SCOREBOARD_BYPASS_EN
    step(1, 1,  8,  0,  0, 0, 2'b01,  8,  0,  1, 32'h100,      1, 0, "raw_wb");
`else
    step(1, 1,  8,  0,  0, 0, 2'b01,  8,  0,  0, 32'h100,      1, 0, "raw_wb");
`endif
    step(1, 1,  8,  0,  0, 0, 2'b00,  0,  0,  1, 32'h0,        0, 0, "raw_release");
    // Register 0 and WAW on 31
    step(1, 1,  0,  0,  0, 1, 2'b00,  0,  0,  1, 32'h0,        0, 0, "fire_rd0");
    step(1, 1,  0,  0, 31, 1, 2'b00,  0,  0,  1, 32'h0,        0, 0, "fire_rd31");
    step(1, 1,  0,  0, 31, 1, 2'b00,  0,  0,  0, 32'h80000000, 1, 0, "waw_stall");
`ifdef SCOREBOARD_BYPASS_EN
    step(1, 1,  0,  0, 31, 1, 2'b10,  0, 31,  1, 32'h80000000, 1, 0, "waw_wb");
    step(1, 1,  0,  0, 31, 1, 2'b00,  0,  0,  0, 32'h80000000, 1, 0, "waw_after");
`else
    step(1, 1,  0,  0, 31, 1, 2'b10,  0, 31,  0, 32'h80000000, 1, 0, "waw_wb");
    step(1, 1,  0,  0, 31, 1, 2'b00,  0,  0,  1, 32'h0,        0, 0, "waw_after");
`endif
    step(1, 0,  0,  0,  0, 0, 2'b01, 31,  0,  1, 32'h80000000, 1, 0, "waw_clear");
    step(1, 0,  0,  0,  0, 0, 2'b00,  0,  0,  1, 32'h0,        0, 0, "waw_empty");
    // Dual writeback
    step(1, 1,  0,  0,  3, 1, 2'b00,  0,  0,  1, 32'h0,        0, 0, "fire_rd3");
    step(1, 1,  0,  0, 17, 1, 2'b00,  0,  0,  1, 32'h8,        1, 0, "fire_rd17");
    step(1, 0,  0,  0,  0, 0, 2'b11,  3, 17,  1, 32'h20008,    2, 0, "dual_wb");
    step(1, 0,  0,  0,  0, 0, 2'b00,  0,  0,  1, 32'h0,        0, 0, "dual_clear");
    step(1, 1,  0,  0, 17, 1, 2'b00,  0,  0,  1, 32'h0,        0, 0, "fire_rd17b");
    step(1, 0,  0,  0,  0, 0, 2'b11, 17, 17,  1, 32'h20000,    1, 0, "same_wb");
    step(1, 0,  0,  0,  0, 0, 2'b00,  0,  0,  1, 32'h0,        0, 0, "same_clear");
    // Error: writeback to r0 is ignored, writeback to idle r5 is flagged
    step(1, 0,  0,  0,  0, 0, 2'b01,  0,  0,  1, 32'h0,        0, 0, "wb_r0");
    step(1, 0,  0,  0,  0, 0, 2'b01,  5,  0,  1, 32'h0,        0, 0, "wb_idle5");
    step(1, 0,  0,  0,  0, 0, 2'b00,  0,  0,  1, 32'h0,        0, 1, "err_set");
    // Reset mid-operation
    step(1, 1,  0,  0,  2, 1, 2'b00,  0,  0,  1, 32'h0,        0, 1, "fire_rd2");
    step(1, 1,  0,  0,  4, 1, 2'b00,  0,  0,  1, 32'h4,        1, 1, "fire_rd4");
    step(1, 1,  0,  0,  6, 1, 2'b00,  0,  0,  1, 32'h14,       2, 1, "fire_rd6");
    step(0, 1,  0,  0,  7, 1, 2'b00,  0,  0,  0, 32'h54,       3, 1, "mid_reset");
    step(1, 0,  0,  0,  0, 0, 2'b00,  0,  0,  1, 32'h0,        0, 0, "post_reset");
    // RAW on rt
    step(1, 1,  0,  0, 12, 1, 2'b00,  0,  0,  1, 32'h0,        0, 0, "fire_rd12");
    step(1, 1,  0, 12,  0, 0, 2'b00,  0,  0,  0, 32'h1000,     1, 0, "rt_stall");
    step(1, 0,  0,  0,  0, 0, 2'b01, 12,  0,  1, 32'h1000,     1, 0, "rt_wb");
    step(1, 0,  0,  0,  0, 0, 2'b00,  0,  0,  1, 32'h0,        0, 0, "rt_clear");
    // A busy rd is not a hazard when the instruction does not write it
    step(1, 1,  0,  0, 20, 1, 2'b00,  0,  0,  1, 32'h0,        0, 0, "fire_rd20");
    step(1, 1,  0,  0, 20, 0, 2'b00,  0,  0,  1, 32'h100000,   1, 0, "rd_no_we");
    step(1, 0,  0,  0,  0, 0, 2'b10,  0, 20,  1, 32'h100000,   1, 0, "rd20_wb");
    step(1, 0,  0,  0,  0, 0, 2'b00,  0,  0,  1, 32'h0,        0, 0, "rd20_clear");
`ifdef SCOREBOARD_BYPASS_EN
    // Set wins over a same-cycle writeback of the same register
    step(1, 1,  0,  0,  9, 1, 2'b00,  0,  0,  1, 32'h0,        0, 0, "fire_rd9");
    step(1, 1,  0,  0,  9, 1, 2'b01,  9,  0,  1, 32'h200,      1, 0, "setwin_fire");
    step(1, 0,  0,  0,  0, 0, 2'b00,  0,  0,  1, 32'h200,      1, 0, "setwin_hold");
    step(1, 0,  0,  0,  0, 0, 2'b01,  9,  0,  1, 32'h200,      1, 0, "setwin_wb");
    step(1, 0,  0,  0,  0, 0, 2'b00,  0,  0,  1, 32'h0,        0, 0, "setwin_clear");
`endif

    @(posedge clock); #1;
    iss_valid = 1'b0; wb_valid = '0;
    repeat (3) @(posedge clock);
    #1;
    n_total++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain got=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
